// File: rtl/regfile_arb_pkg.sv
// Shared sizes and types for the register-file read arbiter and its
// future write-port sibling.
package regfile_arb_pkg;

  localparam int DATA_W_DEF  = 64;
  localparam int ADDR_W_DEF  = 5;
  localparam int NUM_REQ_DEF = 4;

  typedef logic [ADDR_W_DEF-1:0] reg_idx_t;
  typedef logic [DATA_W_DEF-1:0] reg_word_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr,
// wrapping around. Purely combinational so it can sit in front of any register.
module rr_arbiter #(
  parameter  int N     = 4,
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  input  logic             en,
  output logic [N-1:0]     gnt
);

  logic [N-1:0]   mask;
  logic [2*N-1:0] dbl_req;
  logic           found;

  // Lower copy keeps only indices >= ptr; the upper unmasked copy supplies
  // the wrapped-around candidates, so a plain lowest-bit search is fair.
  always_comb begin
    mask = '0;
    for (int j = 0; j < N; j++) begin
      mask[j] = (PTR_W'(j) >= ptr);
    end
    dbl_req = {req, req & mask};
  end

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int j = 0; j < 2*N; j++) begin
      if (en && !found && dbl_req[j]) begin
        gnt[j % N] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_read_arbiter.sv
// Shares the register-file read mux between NUM_REQ requesters: round-robin
// grant, registered mux select, and a tagged response one cycle later.
module regfile_read_arbiter
  import regfile_arb_pkg::*;
#(
  parameter  int NUM_REQ = NUM_REQ_DEF,
  parameter  int DATA_W  = DATA_W_DEF,
  parameter  int ADDR_W  = ADDR_W_DEF,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      hold,
  output logic [ADDR_W-1:0]         mux_sel,
  input  logic [DATA_W-1:0]         mux_data,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_data
);

  logic [ID_W-1:0]   rr_ptr_q,    rr_ptr_d;
  logic [ADDR_W-1:0] mux_sel_q,   mux_sel_d;
  logic              s1_v_q,      s1_v_d;
  logic [ID_W-1:0]   s1_id_q,     s1_id_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_q,    rsp_id_d;
  logic [DATA_W-1:0] rsp_data_q,  rsp_data_d;

  logic              accept;
  logic [ID_W-1:0]   grant_idx;
  logic [ADDR_W-1:0] grant_addr;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .en  (rst_n & ~hold),
    .gnt (req_ready)
  );

  always_comb begin
    accept     = |req_ready;
    grant_idx  = '0;
    grant_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        grant_idx  = ID_W'(i);
        grant_addr = req_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  // Stage 1 latches the winner; stage 2 samples the mux one cycle later, so
  // the 32:1 mux never lies on the arbitration path.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    mux_sel_d   = mux_sel_q;
    s1_v_d      = accept;
    s1_id_d     = s1_id_q;
    rsp_valid_d = s1_v_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    if (accept) begin
      mux_sel_d = grant_addr;
      s1_id_d   = grant_idx;
      rr_ptr_d  = (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
    end
    if (s1_v_q) begin
      rsp_id_d   = s1_id_q;
      rsp_data_d = mux_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      mux_sel_q   <= '0;
      s1_v_q      <= 1'b0;
      s1_id_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      mux_sel_q   <= mux_sel_d;
      s1_v_q      <= s1_v_d;
      s1_id_q     <= s1_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign mux_sel   = mux_sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: doc/regfile_read_arbiter.md
# regfile_read_arbiter

- Shares the single 32:1 × 64-bit register-file read mux between up to NUM_REQ requesters (fetch/decode, operand fetch, debug, etc.).
- Arbitrates round-robin with one grant per cycle and drives the mux select from a register.
- Captures the selected 64-bit word one cycle later and returns it on a shared response bus tagged with the requester ID.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters (2–8)
- DATA_W, 64: mux data width
- ADDR_W, 5: register index width (32 entries)

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst_n  input  1  reset, synchronous, active-low
- req_valid  input  NUM_REQ  per-requester read request
- req_addr  input  NUM_REQ×ADDR_W  register index per requester; stable while valid and not ready
- req_ready  output  NUM_REQ  one-hot grant; combinational from req_valid, hold, rr pointer
- hold  input  1  suppress all grants this cycle (e.g. register-file write in progress)
- mux_sel  output  ADDR_W  registered select to the read mux
- mux_data  input  DATA_W  mux output for mux_sel
- rsp_valid  output  1  response strobe, one cycle per accepted request
- rsp_id  output  $clog2(NUM_REQ)  requester index of the response
- rsp_data  output  DATA_W  registered read data

## Operation
- Grant vector: round-robin over req_valid, starting at index rr_ptr, wrapping NUM_REQ−1 → 0. At most one bit of req_ready is set. All-zero when hold=1 or no valid.
- Accept: req_valid[i] & req_ready[i] at edge N.
  - mux_sel ← req_addr[i]
  - rr_ptr ← (i+1) mod NUM_REQ
  - stage-1 valid s1_v ← 1, s1_id ← i
- Cycle without accept: mux_sel holds its value, rr_ptr holds, s1_v ← 0.
- Stage 2 at edge N+1: rsp_valid ← s1_v, rsp_id ← s1_id, rsp_data ← mux_data (combinational from mux_sel set at N). rsp_data and rsp_id hold their last values when rsp_valid=0.
- No response backpressure: requesters must sink rsp_valid when rsp_id matches.
- Pipeline is fully throughput-capable: back-to-back accepts on consecutive cycles give back-to-back responses.
- Requesters may drop valid before ready without penalty. Dropped requests are not remembered.
- Reset (rst_n=0 at an edge), including mid-operation:
  - rr_ptr=0, mux_sel=0, s1_v=0, s1_id=0, rsp_valid=0, rsp_id=0, rsp_data=0
  - req_ready forced 0 while rst_n=0
  - an in-flight stage-1 request is discarded with no response

## Timing
- Request-to-response latency: 2 edges (accept edge N, rsp_valid high after edge N+1).
- hold acts in the same cycle. It does not affect a request already in stage 1, whose response still issues.
- Simultaneous accept and stage-2 output: independent; both occur.
- Simultaneous requests: the winner is the first valid index at or after rr_ptr. Example with rr_ptr=2 and valids {0,3}: grant 3.
- Arbitration is fair: every valid requester is granted within NUM_REQ accepts.
- Critical path: req_valid → rr arbiter → req_ready / mux_sel D-input. mux_data is sampled only in the next cycle, so the 32:1 mux is not in the grant path.

## Structure
- Package regfile_arb_pkg holds:
  - DATA_W_DEF=64, ADDR_W_DEF=5, NUM_REQ_DEF=4
  - typedef reg_idx_t (logic [4:0])
  - typedef reg_word_t (logic [63:0])
- Sub-module rr_arbiter: parameter N, inputs req[N], ptr, en; output one-hot gnt[N].
  - Implemented as a double-width masked priority encoder.
  - Reusable for the future write-port arbiter.
- Top level holds rr_ptr, mux_sel, and the stage-1 and stage-2 registers.

## Test plan
- Reset: drive rst_n=0 for 2 cycles with all valids high → req_ready=0, mux_sel=0, rsp_valid=0, rsp_data=0. Release → first grant is requester 0.
- Single read: req 1 with addr=7, mux model returns 64'hDEAD_BEEF_0000_0007 → req_ready[1] on cycle 0, mux_sel=7 after edge 0, then rsp_valid=1, rsp_id=1, rsp_data=64'hDEAD_BEEF_0000_0007 after edge 1.
- Round-robin: all 4 valid continuously, addrs 1, 2, 3, 4 → grant order 0, 1, 2, 3, 0. Responses every cycle with ids 0, 1, 2, 3, 0 and matching data.
- hold: all valid, hold=1 for cycles 2–4 → no req_ready in cycles 2–4, rr_ptr frozen, response from the cycle-1 accept still issues. Grants resume in cycle 5 with the next index.
- Wrap and addr 31: rr_ptr=3, valids {3}, addr=31 → grant 3, mux_sel=31, rr_ptr wraps to 0, rsp_data = mux word 31.
- Reset mid-flight: accept at edge N, rst_n=0 at edge N+1 → no rsp_valid ever for that request, all outputs return to reset values.
